// File: rtl/denoise_pkg.sv
// Shared types and defaults for the denoise outlier path.
package denoise_pkg;

    localparam int unsigned N_DEFAULT           = 16;
    localparam int unsigned DONE_SETTLE_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        FINISHED
    } drain_state_e;

endpackage

// File: rtl/outlier_drain_if.sv
// Drain-side bundle: outlier FIFO read port, controller status, output stream and status.
interface outlier_drain_if
    import denoise_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);

    logic         fifo_empty;
    logic [N-1:0] fifo_dout;
    logic         fifo_rd_en;
    logic         ctrl_done;
    logic [N-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic [N-1:0] outlier_count;
    logic         finished;

    modport master (
        input  fifo_empty, fifo_dout, ctrl_done, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, outlier_count, finished
    );

    modport slave (
        output fifo_empty, fifo_dout, ctrl_done, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, outlier_count, finished
    );

endinterface

// File: rtl/outlier_drain_buf.sv
// Local FIFO holding outlier indices between the outlier-FIFO return path and the stream.
module drain_buf #(
    parameter int unsigned N         = 16,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push,
    input  logic [N-1:0]                push_data,
    input  logic                        pop,
    output logic [$clog2(BUF_DEPTH):0]  occ,
    output logic [N-1:0]                head
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [N-1:0]  mem [BUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally; push and pop together leave occupancy unchanged.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/outlier_drain.sv
// Drains the outlier-position FIFO into a valid/ready stream with an end-of-stream marker.
module outlier_drain
    import denoise_pkg::*;
#(
    parameter int unsigned N            = N_DEFAULT,
    parameter int unsigned FIFO_LATENCY = 1,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned DONE_SETTLE  = DONE_SETTLE_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    outlier_drain_if.master bus
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned IW = OW + 1;
    localparam int unsigned DW = $clog2(DONE_SETTLE + 1);

    drain_state_e            state;
    logic [FIFO_LATENCY-1:0] inflight_sr;
    logic [DW-1:0]           done_cnt;
    logic [OW-1:0]           occ;
    logic [N-1:0]            head;
    logic [N-1:0]            count;
    logic [IW-1:0]           inflight;
    logic                    rd_en;
    logic                    push;
    logic                    handshake;
    logic                    end_cond;
    logic                    valid;
    logic                    last;

    drain_buf #(
        .N         (N),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus.fifo_dout),
        .pop       (handshake),
        .occ       (occ),
        .head      (head)
    );

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(FIFO_LATENCY); i++) begin
            inflight = inflight + IW'(inflight_sr[i]);
        end
    end

    // The last buffered entry is held back in DRAIN until its last-ness is known.
    always_comb begin
        push      = inflight_sr[FIFO_LATENCY-1];
        end_cond  = (done_cnt >= DW'(DONE_SETTLE)) && bus.fifo_empty && (inflight_sr == '0);
        rd_en     = (state == DRAIN) && !bus.fifo_empty
                    && ((IW'(occ) + inflight) < IW'(BUF_DEPTH));
        valid     = ((state == DRAIN) && (occ >= OW'(2)))
                    || ((state == FLUSH) && (occ != '0));
        last      = (state == FLUSH) && (occ == OW'(1));
        handshake = valid && bus.m_ready;
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_valid       = valid;
    assign bus.m_last        = last;
    assign bus.m_data        = valid ? head : '0;
    assign bus.outlier_count = count;
    assign bus.finished      = (state == FINISHED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            inflight_sr <= '0;
            done_cnt    <= '0;
            count       <= '0;
        end else begin
            inflight_sr <= (inflight_sr << 1) | FIFO_LATENCY'(rd_en);

            if (!bus.ctrl_done)                    done_cnt <= '0;
            else if (done_cnt < DW'(DONE_SETTLE))  done_cnt <= done_cnt + 1'b1;

            if (handshake && (count != '1)) count <= count + 1'b1;

            case (state)
                IDLE: begin
                    if (end_cond)             state <= FINISHED;
                    else if (!bus.fifo_empty) state <= DRAIN;
                end
                DRAIN: begin
                    if (end_cond) state <= FLUSH;
                end
                FLUSH: begin
                    // An empty flush can only follow a spurious empty deassertion; close the stream.
                    if ((handshake && last) || (occ == '0)) state <= FINISHED;
                end
                FINISHED: state <= FINISHED;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outlier_drain.sv
// Directed bench: a 16-bit and a 4-bit outlier_drain share one modelled outlier FIFO,
// one ctrl_done and one m_ready stream; every beat is checked against an expected list.
module tb_outlier_drain;

    logic        clock;
    logic        reset;
    logic        ctrl_done;
    logic        m_ready;
    logic        wr_en;
    logic        fempty;
    logic        last_rd;
    logic [15:0] wr_data;
    logic [15:0] fdout;
    logic [7:0]  rdy_pat;
    logic [15:0] fq[$];
    logic [15:0] exp_q[$];
    int          idx;
    int          sm_idx;
    int          checks;
    int          errors;
    int          phase;
    int          rdy_len;

    outlier_drain_if #(.N(16)) bg ();
    outlier_drain_if #(.N(4))  sm ();

    assign bg.fifo_empty = fempty;
    assign bg.fifo_dout  = fdout;
    assign bg.ctrl_done  = ctrl_done;
    assign bg.m_ready    = m_ready;
    assign sm.fifo_empty = fempty;
    assign sm.fifo_dout  = fdout[3:0];
    assign sm.ctrl_done  = ctrl_done;
    assign sm.m_ready    = m_ready;

    outlier_drain #(.N(16)) u_big (
        .clock (clock),
        .reset (reset),
        .bus   (bg.master)
    );

    outlier_drain #(.N(4)) u_small (
        .clock (clock),
        .reset (reset),
        .bus   (sm.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Outlier FIFO model with one-cycle read latency; cleared with the controller reset.
    always @(posedge clock) begin
        if (reset) begin
            fq.delete();
            fempty <= 1'b1;
        end else begin
            if (bg.fifo_rd_en && (fq.size() != 0)) fdout <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            fempty <= (fq.size() == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        ctrl_done = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        m_ready   = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset   = 1'b0;
        idx     = 0;
        sm_idx  = 0;
        phase   = 0;
        rdy_pat = 8'hFF;
        rdy_len = 1;
        exp_q.delete();
    endtask

    task automatic check_cleared();
        chk("rst_valid", 32'(bg.m_valid), 32'd0);
        chk("rst_data",  32'(bg.m_data), 32'd0);
        chk("rst_last",  32'(bg.m_last), 32'd0);
        chk("rst_count", 32'(bg.outlier_count), 32'd0);
        chk("rst_fin",   32'(bg.finished), 32'd0);
        chk("rst_rd",    32'(bg.fifo_rd_en), 32'd0);
        chk("rst_sm_valid", 32'(sm.m_valid), 32'd0);
        chk("rst_sm_count", 32'(sm.outlier_count), 32'd0);
    endtask

    // One clock: apply m_ready, check everything visible before the edge, then clock.
    task automatic tick();
        m_ready = rdy_pat[phase % rdy_len];
        phase++;
        #1;
        if (bg.m_valid) begin
            if (idx < exp_q.size()) begin
                chk("data", 32'(bg.m_data), 32'(exp_q[idx]));
                chk("last", 32'(bg.m_last), 32'(idx == exp_q.size() - 1));
            end else begin
                chk("extra_beat", 32'(bg.m_valid), 32'd0);
            end
        end
        if (sm.m_valid) begin
            if (sm_idx < exp_q.size()) begin
                chk("sm_data", 32'(sm.m_data), 32'(exp_q[sm_idx][3:0]));
                chk("sm_last", 32'(sm.m_last), 32'(sm_idx == exp_q.size() - 1));
            end else begin
                chk("sm_extra_beat", 32'(sm.m_valid), 32'd0);
            end
        end
        chk("count", 32'(bg.outlier_count), 32'(idx));
        chk("sm_count", 32'(sm.outlier_count), 32'((sm_idx > 15) ? 15 : sm_idx));
        if (idx < exp_q.size()) chk("early_fin", 32'(bg.finished), 32'd0);
        if (bg.m_valid && m_ready) idx++;
        if (sm.m_valid && m_ready) sm_idx++;
        last_rd = bg.fifo_rd_en;
        @(posedge clock);
        #1;
    endtask

    task automatic write_all();
        foreach (exp_q[i]) begin
            wr_en   = 1'b1;
            wr_data = exp_q[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic run_out(input int budget);
        int n;
        n = 0;
        while (((idx < exp_q.size()) || (sm_idx < exp_q.size())) && (n < budget)) begin
            tick();
            n++;
        end
        chk("beats",     32'(idx), 32'(exp_q.size()));
        chk("sm_beats",  32'(sm_idx), 32'(exp_q.size()));
        chk("fin",       32'(bg.finished), 32'd1);
        chk("sm_fin",    32'(sm.finished), 32'd1);
        chk("end_valid", 32'(bg.m_valid), 32'd0);
        chk("end_count", 32'(bg.outlier_count), 32'(exp_q.size()));
        chk("sm_end_count", 32'(sm.outlier_count),
            32'((exp_q.size() > 15) ? 15 : exp_q.size()));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        apply_reset();
        check_cleared();

        // Single outlier, ctrl_done three cycles after the write.
        exp_q.push_back(16'h0007);
        wr_en   = 1'b1;
        wr_data = 16'h0007;
        tick();
        wr_en = 1'b0;
        tick();
        tick();
        ctrl_done = 1'b1;
        run_out(40);

        // Burst of five with m_ready toggling 1,0,1,1,0.
        apply_reset();
        exp_q   = {16'd3, 16'd9, 16'd12, 16'd20, 16'd31};
        rdy_pat = 8'h0D;
        rdy_len = 5;
        write_all();
        ctrl_done = 1'b1;
        run_out(80);

        // Zero outliers: finished exactly DONE_SETTLE+1 cycles after ctrl_done.
        apply_reset();
        ctrl_done = 1'b1;
        tick();
        tick();
        chk("zero_fin_early", 32'(bg.finished), 32'd0);
        tick();
        chk("zero_fin", 32'(bg.finished), 32'd1);
        chk("zero_sm_fin", 32'(sm.finished), 32'd1);
        repeat (4) tick();
        chk("zero_valid", 32'(bg.m_valid), 32'd0);
        chk("zero_count", 32'(bg.outlier_count), 32'd0);

        // Late write landing in the same cycle ctrl_done rises.
        apply_reset();
        exp_q.push_back(16'd44);
        wr_en     = 1'b1;
        wr_data   = 16'd44;
        ctrl_done = 1'b1;
        tick();
        wr_en = 1'b0;
        run_out(40);

        // Reset mid-stream with a read in flight, then a fresh run of two.
        apply_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(16'h61 + i));
        write_all();
        for (int n = 0; (n < 20) && !((idx >= 2) && last_rd); n++) tick();
        chk("pre_reset_state", 32'((idx >= 2) && last_rd), 32'd1);
        rdy_pat = 8'h00;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check_cleared();
        idx    = 0;
        sm_idx = 0;
        exp_q.delete();
        exp_q   = {16'h0071, 16'h0072};
        rdy_pat = 8'hFF;
        write_all();
        ctrl_done = 1'b1;
        run_out(40);

        // Seventeen outliers: the 4-bit count saturates at 15.
        apply_reset();
        for (int i = 1; i <= 17; i++) exp_q.push_back(16'(i * 3));
        write_all();
        ctrl_done = 1'b1;
        run_out(120);
        chk("sat_count", 32'(sm.outlier_count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outlier_drain.md
# outlier_drain

Consumer-side drain for the outlier-position FIFO filled by the validation controller. Pops outlier indices from the FIFO (fixed read latency), buffers them locally, and presents them as a valid/ready stream with an end-of-stream marker once the controller reports completion and the FIFO is exhausted. It sits between the controller's FIFO read port and the DMA/host-side writer, and also reports the total outlier count.

## Interface
- N, 16, point index width; matches controller point/index width
- FIFO_LATENCY, 1, cycles from fifo_rd_en to valid fifo_dout (1 or 2)
- BUF_DEPTH, 4, local buffer entries; power of two, must be ≥ FIFO_LATENCY+2
- DONE_SETTLE, 2, cycles ctrl_done must be high before an empty FIFO is taken as final

- clock  in  1  clock; all logic rising-edge
- reset  in  1  reset, synchronous, active-high
- fifo_empty  in  1  outlier FIFO empty flag
- fifo_dout  in  N  outlier FIFO read data
- fifo_rd_en  out  1  FIFO pop request
- ctrl_done  in  1  controller finished flag (level, sticky until controller reset)
- m_data  out  N  outlier point index
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_last  out  1  marks final beat; qualified by m_valid
- outlier_count  out  N  beats accepted so far, saturating at 2^N−1
- finished  out  1  stream complete; sticky until reset

## Operation
- States: IDLE → DRAIN → FLUSH → FINISHED.
- IDLE: leave on first fifo_empty=0 (→ DRAIN) or on end condition (→ FINISHED directly, zero-beat stream, no m_valid ever).
- DRAIN: fifo_rd_en = !fifo_empty && (occ + inflight) < BUF_DEPTH; combinational from registered occ/inflight and the fifo_empty input. Inflight is tracked by a FIFO_LATENCY-deep shift register of rd_en bits; data is written into the buffer on the cycle its bit exits.
- Tail hold: head is presented (m_valid=1) only while occ ≥ 2, or in FLUSH. The last element is therefore never emitted until its last-ness is known.
- End condition: done_cnt ≥ DONE_SETTLE && fifo_empty && inflight==0. done_cnt counts consecutive ctrl_done=1 cycles, saturates, and clears on ctrl_done=0. DRAIN → FLUSH on end condition.
- FLUSH: m_valid = occ ≥ 1; m_last = (occ==1). A handshake with m_last → FINISHED.
- FINISHED: finished=1, m_valid=0, fifo_rd_en=0; stays until reset.
- A handshake is m_valid && m_ready. It pops the head and increments outlier_count (saturating). m_data/m_last stay stable while m_valid && !m_ready.
- Buffer pointers are log2(BUF_DEPTH) bits and wrap naturally. occ is log2(BUF_DEPTH)+1 bits. Simultaneous push and pop leaves occ unchanged.
- Reset mid-operation: buffer, inflight, done_cnt, count, and state are cleared. Data returning from reads issued before reset is discarded (the shift register is cleared).

## Timing
- Reset values: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0, outlier_count=0, finished=0, state=IDLE.
- Read latency: rd_en at cycle t → buffer write at edge t+FIFO_LATENCY → earliest m_valid at t+FIFO_LATENCY+1 (subject to the tail hold).
- Throughput with FIFO_LATENCY=1, BUF_DEPTH=4, and m_ready held high: 1 beat/cycle sustained.
- Late write: the controller's final wr_en may coincide with its done rising. The FIFO may deassert empty up to DONE_SETTLE−1 cycles after ctrl_done rises, and that entry must still be drained.
- finished rises the cycle after the m_last handshake, or DONE_SETTLE+1 cycles after ctrl_done rises in the zero-outlier case.

## Structure
- Shared package denoise_pkg holds: default N, state enum (IDLE/DRAIN/FLUSH/FINISHED), and the DONE_SETTLE default.
- One sub-module, drain_buf: BUF_DEPTH×N synchronous FIFO (push/pop/occ/head). The FSM, inflight shift register, done counter, and output counter stay in outlier_drain.

## Test plan
- Single outlier: index 0x0007 written, ctrl_done 3 cycles later → exactly one beat, m_data=7, m_last=1; outlier_count=1; finished rises the next cycle.
- Burst of 5: indices 3,9,12,20,31 back-to-back, m_ready toggling 1,0,1,1,0… → 5 beats in order; data stable while stalled; m_last only on 31; count=5.
- Zero outliers: ctrl_done high, FIFO empty throughout → no m_valid; finished=1 at DONE_SETTLE+1 cycles; count=0.
- Late write: wr_en of index 44 in the same cycle ctrl_done rises → 44 delivered with m_last=1; no premature finish.
- Reset mid-stream: reset after 2 of 6 beats, one read inflight → next cycle all outputs 0; stale inflight data not emitted; new run of 2 entries → count=2.
- Saturation (N=4): 17 outliers → outlier_count holds at 15; all 17 beats delivered; last beat flagged.
